mem_arbiter: RTL and testbench

//  Two-master arbiter for the single-port synchronous data memory. Port 0 is the

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the single-port synchronous data memory.
// A granted master can lock ownership, bounded to MAX_HOLD grants while the other waits.
module mem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

  owner_e        owner_q;
  logic          last_q;
  logic [HW-1:0] hold_q;
  logic          hold_ok;

  // Owner may keep the bus only while under its hold budget, unless uncontended.
  assign hold_ok = (hold_q < HoldMax);

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      if (owner_q == OwnM0 && m0_req && (hold_ok || !m1_req)) begin
        m0_gnt = 1'b1;
      end else if (owner_q == OwnM1 && m1_req && (hold_ok || !m0_req)) begin
        m1_gnt = 1'b1;
      end else if (m0_req && !m1_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req && !m0_req) begin
        m1_gnt = 1'b1;
      end else if (m0_req && m1_req) begin
        if (last_q) m0_gnt = 1'b1;
        else        m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OwnNone;
      last_q    <= 1'b1;
      hold_q    <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt || m1_gnt) begin
        last_q <= m1_gnt;
        if ((m0_gnt && owner_q == OwnM0) || (m1_gnt && owner_q == OwnM1)) begin
          hold_q <= (hold_q == HoldMax) ? hold_q : hold_q + HW'(1);
        end else begin
          hold_q <= '0;
        end
        if (m0_gnt) owner_q <= m0_lock ? OwnM0 : OwnNone;
        else        owner_q <= m1_lock ? OwnM1 : OwnNone;
      end else begin
        owner_q <= OwnNone;
        hold_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked each cycle
// against a grant/ownership model and a reference memory.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAX_HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous memory attached to the arbiter, one-cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner id (-1 none), run = grants received while owning.
  logic [DW-1:0] ref_mem [256];
  int            own = -1, run = 0, last = 1, g;
  logic          exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  logic          x_we, x_lock;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_gnt0", 64'(m0_gnt), 0);
      check("rst_gnt1", 64'(m1_gnt), 0);
      check("rst_mem_we", 64'(mem_we), 0);
      check("rst_mem_addr", 64'(mem_addr), 0);
      check("rst_mem_wdata", 64'(mem_wdata), 0);
      check("rst_rv0", 64'(m0_rvalid), 0);
      check("rst_rv1", 64'(m1_rvalid), 0);
      own = -1; run = 0; last = 1; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    end else begin
      g = -1;
      if (own == 0 && m0_req && (run < MAX_HOLD || !m1_req)) g = 0;
      else if (own == 1 && m1_req && (run < MAX_HOLD || !m0_req)) g = 1;
      else if (m0_req && m1_req) g = 1 - last;
      else if (m0_req) g = 0;
      else if (m1_req) g = 1;
      x_we    = (g == 0) ? m0_we    : (g == 1) ? m1_we    : 1'b0;
      x_lock  = (g == 0) ? m0_lock  : (g == 1) ? m1_lock  : 1'b0;
      x_addr  = (g == 0) ? m0_addr  : (g == 1) ? m1_addr  : '0;
      x_wdata = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
      check("gnt0", 64'(m0_gnt), 64'(g == 0));
      check("gnt1", 64'(m1_gnt), 64'(g == 1));
      check("mem_we", 64'(mem_we), 64'(x_we));
      check("mem_addr", 64'(mem_addr), 64'(x_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(x_wdata));
      check("rvalid0", 64'(m0_rvalid), 64'(exp_rv0));
      check("rvalid1", 64'(m1_rvalid), 64'(exp_rv1));
      if (exp_rv0) check("rdata0", 64'(m0_rdata), 64'(exp_rd));
      if (exp_rv1) check("rdata1", 64'(m1_rdata), 64'(exp_rd));
      exp_rv0 = (g == 0) && !x_we;
      exp_rv1 = (g == 1) && !x_we;
      if (g >= 0) begin
        exp_rd = ref_mem[x_addr[9:2]];
        if (x_we) ref_mem[x_addr[9:2]] = x_wdata;
        if (x_lock) begin
          run = (g == own) ? ((run + 1 > MAX_HOLD) ? MAX_HOLD : run + 1) : 1;
          own = g;
        end else begin
          own = -1; run = 0;
        end
        last = g;
      end else begin
        own = -1; run = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic lock, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic lock, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  logic [9:0] t4_pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) cyc();
    reset = 1'b1;

    // T1: reset in the middle of a read response
    set_m0(1'b1, 1'b0, 1'b0, 32'h8, '0);
    cyc();
    set_m0(1'b1, 1'b0, 1'b1, 32'h10, 32'h1234);
    #1;
    check("t1_pre_mem_we", 64'(mem_we), 1);
    check("t1_pre_rv0", 64'(m0_rvalid), 1);
    reset = 1'b0;
    #1;
    check("t1_gnt0", 64'(m0_gnt), 0);
    check("t1_rv0", 64'(m0_rvalid), 0);
    check("t1_mem_we", 64'(mem_we), 0);
    cyc();
    reset = 1'b1;

    // T2: both read without lock -> strict alternation starting with M0
    for (int i = 0; i < 6; i++) begin
      set_m0(1'b1, 1'b0, 1'b0, 32'(i * 4), '0);
      set_m1(1'b1, 1'b0, 1'b0, 32'(i * 4 + 64), '0);
      #1;
      check("t2_gnt0", 64'(m0_gnt), 64'(i % 2 == 0));
      check("t2_gnt1", 64'(m1_gnt), 64'(i % 2 == 1));
      cyc();
    end
    set_m0(1'b0, 1'b0, 1'b0, '0, '0);

    // T3: m1 writes then reads back 0x40
    set_m1(1'b1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    #1;
    check("t3_wr_gnt1", 64'(m1_gnt), 1);
    cyc();
    set_m1(1'b1, 1'b0, 1'b0, 32'h40, '0);
    cyc();
    set_m1(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("t3_rvalid1", 64'(m1_rvalid), 1);
    check("t3_rdata1", 64'(m1_rdata), 64'h0000_0000_DEAD_BEEF);
    cyc();

    // T4: m0 locks continuously against m1 -> M0 x4, M1 x1, repeating
    t4_pat = 10'b1111011110;
    set_m0(1'b1, 1'b1, 1'b0, 32'h20, '0);
    set_m1(1'b1, 1'b0, 1'b0, 32'h24, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_gnt0", 64'(m0_gnt), 64'(t4_pat[9-i]));
      cyc();
    end

    // T5: locked owner M0 drops req -> M1 granted that same cycle
    #1;
    check("t5_own_gnt0", 64'(m0_gnt), 1);
    cyc();
    m0_req = 1'b0;
    #1;
    check("t5_drop_gnt1", 64'(m1_gnt), 1);
    cyc();

    // T6: idle, then last (M1) must be preserved -> M0 wins the tie
    set_m0(1'b0, 1'b0, 1'b0, 32'h44, 32'h55);
    set_m1(1'b0, 1'b0, 1'b0, 32'h48, 32'h66);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t6_mem_we", 64'(mem_we), 0);
      check("t6_mem_addr", 64'(mem_addr), 0);
      cyc();
    end
    m0_req = 1'b1;
    m1_req = 1'b1;
    #1;
    check("t6_tie_gnt0", 64'(m0_gnt), 1);
    cyc();

    // Random traffic, with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             32'($urandom_range(0, 31)) << 2, $urandom);
      set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             32'($urandom_range(0, 31)) << 2, $urandom);
      cyc();
    end
    reset = 1'b1;
    set_m0(1'b0, 1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
